// File: rtl/ram_port_arbiter.sv
// Single-port main-RAM arbiter: data port has priority, fetch is guaranteed progress
// by a saturating starvation counter; read data returns to its owner one cycle later.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              gclk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  input  logic              IfFlush,
  output logic              IfGnt,
  output logic              IfStall,
  output logic              IfValid,
  output logic [DATA_W-1:0] IfRdata,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DGnt,
  output logic              DValid,
  output logic [DATA_W-1:0] DRdata,
  output logic              RamEn,
  output logic              RamWe,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWdata,
  input  logic [DATA_W-1:0] RamRdata
);

  // A zero limit still needs a 1-bit counter; it simply never reaches a forcing state.
  localparam int unsigned     CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] StarveCnt;
  logic             ForceIf;
  logic             RdIf;
  logic             RdD;

  always_comb begin
    ForceIf = (STARVE_LIMIT != 0) && (StarveCnt == LIMIT);
    DGnt    = ~Reset & DReq & ~(ForceIf & IfReq);
    IfGnt   = ~Reset & IfReq & ~DGnt;
    IfStall = ~Reset & IfReq & ~IfGnt;
  end

  assign RamEn    = IfGnt | DGnt;
  assign RamWe    = DGnt & DWe;
  assign RamAddr  = DGnt ? DAddr : IfAddr;
  assign RamWdata = DWdata;

  assign IfValid = RdIf & ~IfFlush;
  assign DValid  = RdD;
  assign IfRdata = RamRdata;
  assign DRdata  = RamRdata;

  always_ff @(posedge gclk or posedge Reset) begin
    if (Reset) begin
      StarveCnt <= '0;
      RdIf      <= 1'b0;
      RdD       <= 1'b0;
    end else begin
      RdIf <= IfGnt;
      RdD  <= DGnt & ~DWe;
      if (IfGnt || !IfReq)
        StarveCnt <= '0;
      else if (DGnt && (StarveCnt != LIMIT))
        StarveCnt <= StarveCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, scoreboard queue of expected returns,
// plus a second instance with pure data priority.
module tb_ram_port_arbiter;

  logic        gclk = 1'b0;
  logic        Reset;
  logic        IfReq, IfFlush, DReq, DWe;
  logic [15:0] IfAddr, DAddr, DWdata;
  logic        IfGnt, IfStall, IfValid, DGnt, DValid, RamEn, RamWe;
  logic [15:0] IfRdata, DRdata, RamAddr, RamWdata;
  logic [15:0] ramRdata;

  logic        IfGnt0, IfStall0, IfValid0, DGnt0, DValid0, RamEn0, RamWe0;
  logic [15:0] IfRdata0, DRdata0, RamAddr0, RamWdata0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [15:0] mem    [256];
  logic [15:0] refMem [256];

  typedef struct {
    int          cyc;
    logic        ifV;
    logic        dV;
    logic [15:0] data;
  } exp_t;
  exp_t expQ[$];
  exp_t e;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3)) dut (
    .gclk(gclk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfFlush(IfFlush), .IfGnt(IfGnt), .IfStall(IfStall),
    .IfValid(IfValid), .IfRdata(IfRdata),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DGnt(DGnt),
    .DValid(DValid), .DRdata(DRdata),
    .RamEn(RamEn), .RamWe(RamWe), .RamAddr(RamAddr), .RamWdata(RamWdata), .RamRdata(ramRdata)
  );

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(0)) dut0 (
    .gclk(gclk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfFlush(IfFlush), .IfGnt(IfGnt0), .IfStall(IfStall0),
    .IfValid(IfValid0), .IfRdata(IfRdata0),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DGnt(DGnt0),
    .DValid(DValid0), .DRdata(DRdata0),
    .RamEn(RamEn0), .RamWe(RamWe0), .RamAddr(RamAddr0), .RamWdata(RamWdata0), .RamRdata(ramRdata)
  );

  always #5 gclk = ~gclk;

  always @(posedge gclk) cycle <= cycle + 1;

  always @(posedge gclk) begin
    if (RamEn) begin
      if (RamWe) mem[RamAddr[7:0]] <= RamWdata;
      else       ramRdata <= mem[RamAddr[7:0]];
    end
  end

  function automatic void pushExp(logic ifV, logic dV, logic [15:0] d);
    exp_t x;
    x.cyc  = cycle + 1;
    x.ifV  = ifV;
    x.dV   = dV;
    x.data = d;
    expQ.push_back(x);
  endfunction

  // Return-path scoreboard: each entry is tagged with the cycle it belongs to.
  always @(negedge gclk) begin
    while (expQ.size() > 0 && expQ[0].cyc < cycle) void'(expQ.pop_front());
    if (expQ.size() > 0 && expQ[0].cyc == cycle) begin
      e = expQ.pop_front();
      checks++;
      if ({IfValid, DValid} !== {e.ifV, e.dV}) begin
        errors++;
        $display("FAIL valid cyc=%0d: {IfValid,DValid}=%b required %b", cycle, {IfValid, DValid}, {e.ifV, e.dV});
      end
      if (e.ifV) begin
        checks++;
        if (IfRdata !== e.data) begin
          errors++;
          $display("FAIL ifrdata cyc=%0d: got %h required %h", cycle, IfRdata, e.data);
        end
      end
      if (e.dV) begin
        checks++;
        if (DRdata !== e.data) begin
          errors++;
          $display("FAIL drdata cyc=%0d: got %h required %h", cycle, DRdata, e.data);
        end
      end
    end
  end

  task automatic idle_cycle();
    IfReq = 1'b0; DReq = 1'b0; DWe = 1'b0; IfFlush = 1'b0;
    @(negedge gclk);
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
  endtask

  task automatic test_reset();
    IfReq = 1'b1; IfAddr = 16'h0033; DReq = 1'b1; DWe = 1'b0; DAddr = 16'h0020;
    @(negedge gclk);
    checks++;
    if ({IfGnt, DGnt, IfStall, IfValid, DValid, RamEn, RamWe} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b required 0000000", {IfGnt, DGnt, IfStall, IfValid, DValid, RamEn, RamWe});
    end
    checks++;
    if (RamAddr !== 16'h0033) begin
      errors++;
      $display("FAIL reset_addr: got %h required 0033", RamAddr);
    end
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
    Reset = 1'b0; IfReq = 1'b0; DReq = 1'b0;
    idle_cycle();
  endtask

  task automatic test_fetch_only();
    logic [20:0] expv;
    for (int k = 0; k < 3; k++) begin
      IfReq = 1'b1; IfAddr = 16'(k); DReq = 1'b0; IfFlush = 1'b0;
      @(negedge gclk);
      expv = {5'b10010, 16'(k)};
      checks++;
      if ({IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr} !== expv) begin
        errors++;
        $display("FAIL fetch_only k=%0d: got %h required %h", k, {IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr}, expv);
      end
      pushExp(1'b1, 1'b0, refMem[k]);
      @(posedge gclk); #1;
    end
    idle_cycle();
  endtask

  task automatic test_collision();
    bit          dw [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [20:0] expv;
    logic [15:0] a;
    IfReq = 1'b1; IfAddr = 16'h0005; DReq = 1'b1; DWe = 1'b0; DAddr = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      a    = dw[i] ? 16'h0020 : 16'h0005;
      expv = {~dw[i], dw[i], dw[i], 1'b1, 1'b0, a};
      checks++;
      if ({IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr} !== expv) begin
        errors++;
        $display("FAIL collision i=%0d: got %h required %h", i, {IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr}, expv);
      end
      pushExp(~dw[i], dw[i], refMem[a[7:0]]);
      @(posedge gclk); #1;
    end
    idle_cycle();
  endtask

  task automatic test_write_read();
    IfReq = 1'b0; DReq = 1'b1; DWe = 1'b1; DAddr = 16'h0040; DWdata = 16'hBEEF;
    @(negedge gclk);
    checks++;
    if ({IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr, RamWdata} !== {5'b01011, 16'h0040, 16'hBEEF}) begin
      errors++;
      $display("FAIL write: got %h required %h", {IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr, RamWdata},
               {5'b01011, 16'h0040, 16'hBEEF});
    end
    refMem[8'h40] = 16'hBEEF;
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
    DWe = 1'b0; DWdata = 16'h0000;
    @(negedge gclk);
    checks++;
    if ({IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr} !== {5'b01010, 16'h0040}) begin
      errors++;
      $display("FAIL read_after_write: got %h required %h", {IfGnt, DGnt, IfStall, RamEn, RamWe, RamAddr}, {5'b01010, 16'h0040});
    end
    pushExp(1'b0, 1'b1, refMem[8'h40]);
    @(posedge gclk); #1;
    DReq = 1'b0;
    @(negedge gclk);
    checks++;
    if ({RamEn, RamWe} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle: {RamEn,RamWe}=%b required 00", {RamEn, RamWe});
    end
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
  endtask

  task automatic test_flush();
    IfReq = 1'b1; IfAddr = 16'h0010; DReq = 1'b0; IfFlush = 1'b0;
    @(negedge gclk);
    checks++;
    if ({IfGnt, RamEn, RamAddr} !== {2'b11, 16'h0010}) begin
      errors++;
      $display("FAIL flush_grant0: got %h required %h", {IfGnt, RamEn, RamAddr}, {2'b11, 16'h0010});
    end
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
    IfFlush = 1'b1; IfAddr = 16'h0080;
    @(negedge gclk);
    checks++;
    if ({IfGnt, IfStall, RamAddr} !== {2'b10, 16'h0080}) begin
      errors++;
      $display("FAIL flush_grant1: got %h required %h", {IfGnt, IfStall, RamAddr}, {2'b10, 16'h0080});
    end
    pushExp(1'b1, 1'b0, refMem[8'h80]);
    @(posedge gclk); #1;
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    bit          dw [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] a;
    IfReq = 1'b1; IfAddr = 16'h0007; DReq = 1'b1; DWe = 1'b0; DAddr = 16'h0020;
    @(negedge gclk);
    checks++;
    if ({IfGnt, DGnt, IfStall} !== 3'b011) begin
      errors++;
      $display("FAIL rmid_grant: got %b required 011", {IfGnt, DGnt, IfStall});
    end
    @(posedge gclk); #2;
    checks++;
    if ({DValid, DRdata} !== {1'b1, refMem[8'h20]}) begin
      errors++;
      $display("FAIL rmid_pre: got %h required %h", {DValid, DRdata}, {1'b1, refMem[8'h20]});
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({IfGnt, DGnt, IfStall, IfValid, DValid, RamEn, RamWe} !== 7'b0) begin
      errors++;
      $display("FAIL rmid_async: got %b required 0000000", {IfGnt, DGnt, IfStall, IfValid, DValid, RamEn, RamWe});
    end
    @(negedge gclk);
    pushExp(1'b0, 1'b0, 16'h0);
    @(posedge gclk); #1;
    Reset = 1'b0;
    // A cleared counter gives three data wins before fetch is forced through.
    for (int i = 0; i < 4; i++) begin
      @(negedge gclk);
      checks++;
      if ({IfGnt, DGnt, IfStall} !== {~dw[i], dw[i], dw[i]}) begin
        errors++;
        $display("FAIL rmid_after i=%0d: got %b required %b", i, {IfGnt, DGnt, IfStall}, {~dw[i], dw[i], dw[i]});
      end
      a = dw[i] ? 16'h0020 : 16'h0007;
      pushExp(~dw[i], dw[i], refMem[a[7:0]]);
      @(posedge gclk); #1;
    end
    idle_cycle();
  endtask

  task automatic test_starve_zero();
    IfReq = 1'b1; IfAddr = 16'h0009; DReq = 1'b1; DWe = 1'b0; DAddr = 16'h0021;
    for (int i = 0; i < 8; i++) begin
      @(negedge gclk);
      checks++;
      if ({IfGnt0, IfStall0, DGnt0} !== 3'b011) begin
        errors++;
        $display("FAIL starve0 i=%0d: {IfGnt,IfStall,DGnt}=%b required 011", i, {IfGnt0, IfStall0, DGnt0});
      end
      @(posedge gclk); #1;
    end
    IfReq = 1'b0; DReq = 1'b0;
    @(posedge gclk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'(16'h1000 + i);
      refMem[i] = 16'(16'h1000 + i);
    end
    Reset = 1'b1; IfReq = 1'b0; IfFlush = 1'b0; DReq = 1'b0; DWe = 1'b0;
    IfAddr = '0; DAddr = '0; DWdata = '0;
    @(posedge gclk); #1;
    test_reset();
    test_fetch_only();
    test_collision();
    test_write_read();
    test_flush();
    test_reset_mid();
    test_starve_zero();
    @(negedge gclk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Single-port main-RAM arbiter that shares one synchronous RAM between the instruction fetch port and the data load/store port. It sits between the core and main RAM. It grants at most one access per cycle and routes read data back to its owner one cycle later. It also raises a stall to fetch whenever fetch is denied, and discards in-flight fetch reads killed by a jump flush. Data port has fixed priority, bounded by an anti-starvation counter that guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM word width
- STARVE_LIMIT, 3, consecutive fetch denials after which fetch wins; 0 = pure data priority

Ports:
- gclk  in  1  global clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- IfReq  in  1  fetch read request, held until granted
- IfAddr  in  ADDR_W  fetch address
- IfFlush  in  1  discard fetch read returning this cycle
- IfGnt  out  1  fetch request accepted this cycle
- IfStall  out  1  IfReq & ~IfGnt
- IfValid  out  1  IfRdata valid
- IfRdata  out  DATA_W  fetch read data
- DReq  in  1  data request, held until granted
- DWe  in  1  1 = write, 0 = read
- DAddr  in  ADDR_W  data address
- DWdata  in  DATA_W  write data
- DGnt  out  1  data request accepted this cycle
- DValid  out  1  DRdata valid (reads only)
- DRdata  out  DATA_W  data read data
- RamEn  out  1  RAM access this cycle
- RamWe  out  1  RAM write strobe
- RamAddr  out  ADDR_W  RAM address
- RamWdata  out  DATA_W  RAM write data
- RamRdata  in  DATA_W  RAM read data, valid cycle after RamEn & ~RamWe

## Operation
- Grant is combinational:
  - ForceIf = (STARVE_LIMIT != 0) & (StarveCnt == STARVE_LIMIT).
  - DGnt = DReq & ~(ForceIf & IfReq).
  - IfGnt = IfReq & ~DGnt.
  - Both grants are 0 while Reset is high.
- RAM mux:
  - RamEn = IfGnt | DGnt.
  - RamWe = DGnt & DWe.
  - RamAddr = DGnt ? DAddr : IfAddr.
  - RamWdata = DWdata.
  - When idle, RamAddr = IfAddr and RamWe = 0.
- Starvation counter, width clog2(STARVE_LIMIT+1):
  - Increments when IfReq & DGnt, saturating at STARVE_LIMIT.
  - Clears when IfGnt or ~IfReq.
- In-flight owner registers:
  - RdIf <= IfGnt.
  - RdD <= DGnt & ~DWe.
  - At most one of RdIf and RdD is set.
- Return path:
  - IfValid = RdIf & ~IfFlush.
  - DValid = RdD.
  - IfRdata = DRdata = RamRdata, combinational. Data is don't-care when the corresponding valid is 0.
- Writes complete at the grant edge and produce no DValid.
- Reset clears StarveCnt, RdIf and RdD.
  - Reset values: IfGnt, DGnt, IfStall, IfValid, DValid, RamEn, RamWe all 0.
  - Reset values: RamAddr = IfAddr, data buses = RamRdata.

## Timing
- Grant latency 0: a request seen in cycle N is granted in cycle N if it wins.
- The requester must hold Req, Addr, We and Wdata stable until its Gnt is sampled high at a clock edge.
- Read latency 1: data granted in cycle N appears with Valid in cycle N+1.
- Back-to-back grants every cycle are allowed. Throughput is 1 access/cycle total.
- IfFlush affects only the return in its own cycle. An IF request granted in the same cycle as IfFlush is not flushed.
- Simultaneous IfReq & DReq:
  - Data wins while StarveCnt < STARVE_LIMIT.
  - IF wins when StarveCnt == STARVE_LIMIT.
  - Worst-case fetch wait with continuous DReq is STARVE_LIMIT cycles.
- Reset asserted mid-read: the pending Valid is dropped. No return is produced after deassertion.
- Reset deasserted: arbitration resumes on the first rising edge with Reset low.

## Test plan
- Fetch only:
  - Stimulus: IfReq=1 with IfAddr = 0, 1, 2 in consecutive cycles; RAM preloaded with mem[i] = 0x1000+i.
  - Required: IfGnt=1 every cycle, IfStall=0. IfValid=1 from cycle 1 with IfRdata 0x1000, 0x1001, 0x1002.
- Collision, STARVE_LIMIT=3:
  - Stimulus: IfReq and DReq (read, DAddr=0x20) both held high.
  - Required: DGnt in cycles 0-2 and IfStall=1 in those cycles. IfGnt in cycle 3, then DGnt again in cycle 4.
  - Required: DValid in cycles 1-3; IfValid in cycle 4.
- Write then read:
  - Stimulus: DWe=1, DAddr=0x40, DWdata=0xBEEF in cycle 0; read of 0x40 in cycle 1.
  - Required: RamWe=1 only in cycle 0, no DValid in cycle 1. DValid=1 with DRdata=0xBEEF in cycle 2.
- Flush:
  - Stimulus: IF granted in cycle 0; IfFlush=1 in cycle 1 while a new IfReq to 0x80 is granted.
  - Required: IfValid=0 in cycle 1. IfValid=1 with mem[0x80] in cycle 2.
- Reset mid-read:
  - Stimulus: data read granted in cycle 0; Reset asserted asynchronously in cycle 1.
  - Required: DValid=0 immediately and all grants 0. After release, StarveCnt=0 and normal arbitration.
- STARVE_LIMIT=0 with continuous DReq:
  - Required: IfGnt never asserted and IfStall stays 1.
